// File: rtl/pon_seq_pkg.sv
// pon_pkg: sequencer state encoding, default timing constants and counter sizing helper
package pon_pkg;
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      UP_EN  = 3'd1,
      UP_GAP = 3'd2,
      RUN    = 3'd3,
      DOWN   = 3'd4,
      FAULT  = 3'd5
   } pon_state_t;
   localparam int PON_TSTEP = 100;
   localparam int PON_TOUT  = 500;
   localparam int PON_NRAIL = 4;
   function automatic int cnt_width(input int a, input int b);
      return $clog2(a > b ? a : b) + 1;
   endfunction
endpackage

// File: rtl/pon_seq_if.sv
// pon_seq_if: power request, per-rail power-good and status between board and sequencer
interface pon_seq_if import pon_pkg::*; #(parameter int N = PON_NRAIL) ();
   logic d;
   logic [N-1:0] pg;
   logic [N-1:0] en;
   logic rdy;
   logic flt;
   pon_state_t state;
   modport master(output d, pg, input en, rdy, flt, state);
   modport slave(input d, pg, output en, rdy, flt, state);
endinterface

// File: rtl/pon_seq_timer.sv
// pon_timer: saturating cycle counter shared by the rail gap and power-good timeout phases
module pon_timer import pon_pkg::*; #(
   parameter int W = cnt_width(PON_TSTEP, PON_TOUT)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         ld,
   input  logic         inc,
   input  logic [W-1:0] val,
   input  logic [W-1:0] tval,
   output logic         tc
);
   logic [W-1:0] cnt;
   // clear beats load beats count; counting holds at all-ones instead of wrapping
   always_ff @(posedge clk or posedge rst)
      if (rst) cnt <= '0;
      else if (clr) cnt <= '0;
      else if (ld) cnt <= val;
      else if (inc && cnt != '1) cnt <= cnt + W'(1);
   assign tc = cnt == tval;
endmodule

// File: rtl/pon_seq.sv
// pon_seq: enables rails in order with power-good timeouts, disables in reverse, trips all-off on faults
module pon_seq import pon_pkg::*; #(
   parameter int N     = PON_NRAIL,
   parameter int TSTEP = PON_TSTEP,
   parameter int TOUT  = PON_TOUT
) (
   input logic       clk,
   input logic       rst,
   pon_seq_if.slave  bus
);
   localparam int W  = cnt_width(TSTEP, TOUT);
   localparam int IW = N > 1 ? $clog2(N) : 1;
   pon_state_t state, nxt;
   logic [IW-1:0] idx, idx_n;
   logic [N-1:0] en, en_n, conf;
   logic [W-1:0] tval;
   logic rdy, flt, clr, inc, tc, bad, tmo, last;
   pon_timer #(.W(W)) u_tmr (
      .clk(clk), .rst(rst), .clr(clr), .ld(1'b0), .inc(inc),
      .val('0), .tval(tval), .tc(tc)
   );
   assign last = int'(idx) == N - 1;
   assign bad  = |(conf & ~bus.pg);
   assign tmo  = state == UP_EN && !bus.pg[idx] && tc;
   assign inc  = state == UP_EN || state == UP_GAP || state == DOWN;
   assign tval = state == UP_EN ? W'(TOUT - 1) : W'(TSTEP - 1);
   // rails already confirmed good; the rail still being brought up in UP_EN is excluded
   always_comb begin
      for (int j = 0; j < N; j++) conf[j] = j < int'(idx) || (j == int'(idx) && state != UP_EN);
   end
   // next state, rail index and enable image; faults outrank a falling request
   always_comb begin
      nxt = state;
      idx_n = idx;
      en_n = en;
      clr = 1'b0;
      case (state)
         IDLE: begin
            idx_n = '0;
            en_n = '0;
            if (bus.d && !flt) begin
               nxt = UP_EN;
               en_n[0] = 1'b1;
               clr = 1'b1;
            end
         end
         UP_EN, UP_GAP, RUN: begin
            if (bad || tmo) begin
               nxt = FAULT;
               en_n = '0;
            end else if (!bus.d) begin
               nxt = DOWN;
               en_n[idx] = 1'b0;
               clr = 1'b1;
            end else if (state == UP_EN && bus.pg[idx]) begin
               nxt = last ? RUN : UP_GAP;
               clr = 1'b1;
            end else if (state == UP_GAP && tc) begin
               nxt = UP_EN;
               idx_n = idx + IW'(1);
               en_n[idx_n] = 1'b1;
               clr = 1'b1;
            end
         end
         DOWN: begin
            if (tc) begin
               clr = 1'b1;
               if (idx == '0) nxt = IDLE;
               else begin
                  idx_n = idx - IW'(1);
                  en_n[idx_n] = 1'b0;
               end
            end
         end
         FAULT: begin
            en_n = '0;
            if (!bus.d) nxt = IDLE;
         end
         default: begin
            nxt = IDLE;
            en_n = '0;
         end
      endcase
   end
   // state and output registers; reset drops every enable at once
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= IDLE;
         idx <= '0;
         en <= '0;
         rdy <= 1'b0;
         flt <= 1'b0;
      end else begin
         state <= nxt;
         idx <= idx_n;
         en <= en_n;
         rdy <= nxt == RUN;
         flt <= nxt == FAULT;
      end
   assign bus.en = en;
   assign bus.rdy = rdy;
   assign bus.flt = flt;
   assign bus.state = state;
endmodule

// File: tb/tb_pon_seq.sv
// tb_pon_seq: randomized rail response delays checked against a timestamp model of the sequencing rules
module tb_pon_seq;
   import pon_pkg::*;
   localparam int N = 4, TSTEP = 10, TOUT = 50;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int cyc = 0, checks = 0, failures = 0;
   int age[N];
   int dl[N];
   bit kill[N];
   pon_seq_if #(.N(N)) bus();
   pon_seq #(.N(N), .TSTEP(TSTEP), .TOUT(TOUT)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   // a rail reports good once it has been enabled for dl[i] cycles, unless forced low
   task automatic setpg();
      for (int i = 0; i < N; i++) bus.pg[i] = age[i] >= dl[i] && !kill[i];
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      for (int i = 0; i < N; i++) age[i] = bus.en[i] ? age[i] + 1 : 0;
      setpg();
   endtask

   // expected enable times: r[i+1] = r[i] + pg delay + gap; timeout at r[i] + TOUT
   task automatic seq_up(output bit faulted);
      int r[N];
      int fi;
      int tend;
      int ee;
      fi = -1;
      bus.d = 1'b1;
      r[0] = cyc + 1;
      for (int i = 0; i < N; i++) begin
         if (fi < 0 && dl[i] > TOUT) fi = i;
         if (i < N - 1) r[i+1] = r[i] + dl[i] + TSTEP;
      end
      faulted = fi >= 0;
      tend = faulted ? r[fi] + TOUT : r[N-1] + dl[N-1];
      while (cyc <= tend) begin
         tick();
         ee = 0;
         for (int i = 0; i < N; i++) if (r[i] <= cyc && !(faulted && cyc >= tend)) ee |= 1 << i;
         chk("up_en", 32'(bus.en), ee);
         chk("up_rdy", 32'(bus.rdy), 32'(!faulted && cyc >= tend));
         chk("up_flt", 32'(bus.flt), 32'(faulted && cyc >= tend));
      end
      chk("up_state", 32'(bus.state), faulted ? 32'(FAULT) : 32'(RUN));
   endtask

   // rail i goes off (N-1-i)*TSTEP after the request drops; idle after N*TSTEP
   task automatic seq_down(input bit tog);
      int f;
      int tg;
      int ee;
      bus.d = 1'b0;
      f = cyc + 1;
      tg = tog ? f + int'($urandom_range(0, N * TSTEP - 2)) : -1;
      while (cyc < f + N * TSTEP) begin
         tick();
         ee = 0;
         for (int i = 0; i < N; i++) if (cyc < f + (N - 1 - i) * TSTEP) ee |= 1 << i;
         chk("dn_en", 32'(bus.en), ee);
         chk("dn_rdy", 32'(bus.rdy), 0);
         chk("dn_state", 32'(bus.state), cyc >= f + N * TSTEP ? 32'(IDLE) : 32'(DOWN));
         if (cyc == tg) bus.d = 1'b1;
      end
   endtask

   task automatic seq_flt(input bit wd);
      int j;
      j = int'($urandom_range(0, N - 1));
      repeat (int'($urandom_range(1, 8))) begin
         tick();
         chk("run_rdy", 32'(bus.rdy), 1);
      end
      kill[j] = 1'b1;
      setpg();
      if (wd) bus.d = 1'b0;
      tick();
      chk("pgl_en", 32'(bus.en), 0);
      chk("pgl_flt", 32'(bus.flt), 1);
      chk("pgl_rdy", 32'(bus.rdy), 0);
      chk("pgl_state", 32'(bus.state), 32'(FAULT));
      kill[j] = 1'b0;
      setpg();
      if (!wd) begin
         repeat (int'($urandom_range(2, 10))) begin
            tick();
            chk("pgl_hold", 32'(bus.flt), 1);
         end
         bus.d = 1'b0;
      end
      tick();
      chk("pgl_clr", 32'(bus.flt), 0);
      chk("pgl_idle", 32'(bus.state), 32'(IDLE));
   endtask

   task automatic leave_fault();
      repeat (int'($urandom_range(1, 6))) begin
         tick();
         chk("to_hold", 32'(bus.flt), 1);
         chk("to_en", 32'(bus.en), 0);
      end
      bus.d = 1'b0;
      tick();
      chk("to_clr", 32'(bus.flt), 0);
      chk("to_idle", 32'(bus.state), 32'(IDLE));
   endtask

   initial begin
      bit fl;
      bus.d = 1'b0;
      bus.pg = '0;
      for (int i = 0; i < N; i++) begin
         age[i] = 0;
         dl[i] = 6;
         kill[i] = 1'b0;
      end
      tick();
      tick();
      chk("rst_en", 32'(bus.en), 0);
      chk("rst_rdy", 32'(bus.rdy), 0);
      chk("rst_flt", 32'(bus.flt), 0);
      chk("rst_state", 32'(bus.state), 32'(IDLE));
      rst = 1'b0;
      tick();
      chk("idle_state", 32'(bus.state), 32'(IDLE));
      seq_up(fl);
      seq_down(1'b0);
      tick();
      chk("idle_en", 32'(bus.en), 0);
      dl[2] = TOUT + 1;
      seq_up(fl);
      leave_fault();
      dl[2] = TOUT;
      seq_up(fl);
      seq_flt(1'b1);
      dl[2] = 6;
      bus.d = 1'b1;
      repeat (9) tick();
      #2 rst = 1'b1;
      #1;
      chk("arst_en", 32'(bus.en), 0);
      chk("arst_rdy", 32'(bus.rdy), 0);
      chk("arst_flt", 32'(bus.flt), 0);
      chk("arst_state", 32'(bus.state), 32'(IDLE));
      tick();
      rst = 1'b0;
      seq_up(fl);
      seq_down(1'b1);
      seq_up(fl);
      seq_down(1'b0);
      dl[0] = TOUT + 5;
      seq_up(fl);
      #2 rst = 1'b1;
      #1;
      chk("arst_fltclr", 32'(bus.flt), 0);
      tick();
      rst = 1'b0;
      bus.d = 1'b0;
      tick();
      chk("arst_idle", 32'(bus.state), 32'(IDLE));
      repeat (10) begin
         for (int i = 0; i < N; i++) dl[i] = int'($urandom_range(1, 20));
         if ($urandom_range(0, 3) == 0) dl[int'($urandom_range(0, N - 1))] = TOUT + 1 + int'($urandom_range(0, 20));
         seq_up(fl);
         if (fl) leave_fault();
         else case ($urandom_range(0, 2))
            0: seq_down(1'b0);
            1: seq_down(1'b1);
            default: seq_flt(1'($urandom_range(0, 1)));
         endcase
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
